ps2_frame_rx: RTL and testbench
===============================

Name: ps2_frame_rx

Overview:
- Upstream receive stage for the keyboard path. Samples the raw PS/2 clock and data pins, detects kclk falling edges and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Delivers each validated byte as a one-cycle strobe to the scan-code handling stage that feeds the UART transmit path.
- Flags framing, parity and timeout errors on a separate one-cycle strobe.

Parameters:
- TIMEOUT_CYC, 100000, clk cycles without a kclk falling edge while mid-frame before the frame is aborted (1 ms at 100 MHz); minimum 16.
- FILTER_LEN, 8, consecutive clk cycles the synchronised kclk must hold a new level before the filtered kclk follows it (used only with PS2_FILTER_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- kclk  input  1  raw PS/2 clock pin, asynchronous to clk.
- kdata  input  1  raw PS/2 data pin, asynchronous to clk.
- data  output  8  last good received byte; holds its value until the next good frame.
- valid  output  1  one-cycle strobe: data updated with a good frame.
- err  output  1  one-cycle strobe: frame rejected (start/parity/stop/timeout).
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync release internally irrelevant; async on all flops):
  - data=0, valid=0, err=0, busy=0, state=IDLE, bit counter=0, timeout counter=0.
  - Synchroniser and filter flops reset to 1 (bus idle high).
- Input sync: kclk and kdata each pass through two flops (s1, s2). Edge detect: fall = kclk_prev & ~kclk_cur, where kclk_cur is s2 (or the filter output when PS2_FILTER_EN is defined) and kclk_prev is kclk_cur delayed one cycle. kdata is sampled from its s2 on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if sampled kdata=0 go to DATA with bit counter 0; if kdata=1 (bad start), stay IDLE and pulse err.
  - DATA: on each fall shift kdata into bit[counter] (LSB first) and increment the counter. After the 8th bit go to PARITY.
  - PARITY: on fall capture the parity bit and go to STOP.
  - STOP: on fall, check that the XOR of the 8 data bits and the parity bit is 1 (odd parity) and that stop=1.
    - Both pass: data<=byte, valid=1 for one cycle.
    - Either fails: err=1 for one cycle, data unchanged.
    - In both cases go to IDLE.
- Latency, filter disabled: a stable stop-bit kclk pin fall produces valid=1 registered on the 3rd rising clk edge after the pin change (2 sync + edge/FSM register). Enabling the filter adds FILTER_LEN cycles.
- Timeout:
  - Counter clears on every fall and in IDLE, and counts each cycle in DATA/PARITY/STOP.
  - On reaching TIMEOUT_CYC-1 without a fall: go to IDLE, pulse err, discard the partial byte.
  - If a fall and the timeout terminal count occur in the same cycle, the fall wins and the counter clears.
- valid and err are never high in the same cycle. Back-to-back frames need no idle gap beyond one kclk period; the FSM accepts a start bit on the first fall after STOP.
- busy is high from the clk cycle after the start-bit fall until the cycle STOP/timeout returns to IDLE.
- Reset asserted mid-frame aborts immediately with no valid or err pulse; after release, the first frame with a proper start is received normally.

Optional Feature:
- Macro PS2_FILTER_EN.
- Defined: a glitch filter sits between the kclk synchroniser and the edge detector.
  - Its output changes only after s2 has held the opposite level for FILTER_LEN consecutive cycles.
  - Its counter clears whenever s2 equals the filter output.
  - kdata is unfiltered but is sampled from its s2 in the same cycle as the filtered fall.
- Undefined: s2 of kclk drives the edge detector directly; FILTER_LEN is ignored and no filter logic is generated.

Test Plan:
- Good frame: send 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz kclk -> exactly one valid pulse, data=0x1C, err stays 0, busy low afterwards.
- Back-to-back frames 0xF0 (parity 1) then 0x1C, one kclk period apart -> two valid pulses with data=0xF0 then 0x1C, no err.
- Parity error: send 0x1C with parity bit 1 -> one err pulse, no valid, data keeps its previous value. Repeat with stop=0 -> err, no valid.
- Timeout: send start plus 3 data bits, then hold kclk high for TIMEOUT_CYC+10 cycles -> one err pulse exactly TIMEOUT_CYC cycles after the last fall, busy drops. A following good 0x1C frame -> valid, data=0x1C.
- Reset mid-frame: assert rst after 5 data bits -> outputs 0 immediately, no valid/err. After release, a good 0x5A frame -> valid, data=0x5A.
- With PS2_FILTER_EN, FILTER_LEN=8: inject 3-cycle low glitches on kclk between real edges during a 0x1C frame -> data=0x1C, single valid, no err. Without the macro, the same stimulus -> err or corrupt byte (the bench confirms the filter is absent).

Source files
------------

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 keyboard receive stage.
// Synchronises the raw kclk/kdata pins, detects kclk falling edges and
// assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Good bytes leave on a one-cycle valid strobe; rejected frames (bad start,
// parity, stop or mid-frame timeout) leave on a one-cycle err strobe.
// Optional kclk glitch filter: define PS2_FILTER_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a start bit (kdata=0 on a kclk fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the odd-parity bit
// STOP   | waiting for the stop bit; byte is checked and delivered here
module ps2_frame_rx #(
    parameter int TIMEOUT_CYC = 100000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_TC = TW'(TIMEOUT_CYC - 1);

    // Parameter sanity checks at elaboration time.
    if (TIMEOUT_CYC < 16) begin : g_to_chk
        $error("ps2_frame_rx: TIMEOUT_CYC must be at least 16");
    end
    if (FILTER_LEN < 1) begin : g_fl_chk
        $error("ps2_frame_rx: FILTER_LEN must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic kclk_s1_q, kclk_s2_q;
    logic kdata_s1_q, kdata_s2_q;
    logic kclk_cur;
    logic kclk_prev_q;
    logic fall;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Two-flop synchronisers for the asynchronous pins; idle bus is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_s1_q  <= 1'b1;
            kclk_s2_q  <= 1'b1;
            kdata_s1_q <= 1'b1;
            kdata_s2_q <= 1'b1;
        end else begin
            kclk_s1_q  <= kclk;
            kclk_s2_q  <= kclk_s1_q;
            kdata_s1_q <= kdata;
            kdata_s2_q <= kdata_s1_q;
        end
    end

`ifdef PS2_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FL_TC = FW'(FILTER_LEN - 1);

    logic          kclk_filt_q, kclk_filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    // Filter output follows s2 only after FILTER_LEN consecutive opposite samples.
    always_comb begin
        kclk_filt_d = kclk_filt_q;
        filt_cnt_d  = filt_cnt_q;
        if (kclk_s2_q == kclk_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FL_TC) begin
            kclk_filt_d = kclk_s2_q;
            filt_cnt_d  = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    // Glitch filter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_filt_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            kclk_filt_q <= kclk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign kclk_cur = kclk_filt_q;
`else
    assign kclk_cur = kclk_s2_q;
`endif

    // Delayed copy of the (filtered) kclk for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_prev_q <= 1'b1;
        end else begin
            kclk_prev_q <= kclk_cur;
        end
    end

    assign fall = kclk_prev_q & ~kclk_cur;

    // Next-state, frame assembly, checking and timeout.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        if (state_q == S_IDLE || fall) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    if (!kdata_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d[bit_cnt_q] = kdata_s2_q;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = kdata_s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    if ((^{shift_q, par_q}) && kdata_s2_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fall in the same cycle as terminal count wins, so only abort without one.
        if (state_q != S_IDLE && !fall && to_cnt_q == TO_TC) begin
            state_d  = S_IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Testbench for ps2_frame_rx: table of directed frames plus hand-written
// sequences for latency, bad start, timeout, mid-frame reset and kclk glitches.
module tb_ps2_frame_rx;

    localparam int T  = 200;
    localparam int FL = 8;
    localparam int H  = 24;
`ifdef PS2_FILTER_EN
    localparam int EXTRA = FL;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk;
    logic       rst;
    logic       kclk;
    logic       kdata;
    logic [7:0] data;
    logic       valid;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int ecnt   = 0;
    int both   = 0;

    ps2_frame_rx #(.TIMEOUT_CYC(T), .FILTER_LEN(FL)) dut (
        .clk   (clk),
        .rst   (rst),
        .kclk  (kclk),
        .kdata (kdata),
        .data  (data),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) vcnt++;
            if (err) ecnt++;
            if (valid && err) both++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        kdata = b;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        repeat (H) @(negedge clk);
        kclk = 1'b1;
    endtask

    task automatic glitch_bit(input logic b);
        @(negedge clk);
        kdata = b;
        repeat (12) @(negedge clk);
        kclk = 1'b0;
        repeat (3) @(negedge clk);
        kclk = 1'b1;
        repeat (H - 15) @(negedge clk);
        kclk = 1'b0;
        repeat (H) @(negedge clk);
        kclk = 1'b1;
    endtask

    // Full frame; lat = clk edges from the stop-bit pin fall to valid/err.
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_b, output int lat);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        @(negedge clk);
        kdata = stop_b;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        lat = 0;
        for (int i = 1; i <= H; i++) begin
            @(posedge clk);
            #1;
            if ((valid || err) && lat == 0) lat = i;
        end
        kclk = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       par_flip;
        logic       stop_b;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, e0, lat;
        logic [7:0] d;

        vecs[0] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0};
        vecs[1] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vecs[2] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h1C};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, 0, 1, 8'h1C};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 0, 1, 8'hA5};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};
        vecs[7] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};

        rst   = 1'b1;
        kclk  = 1'b1;
        kdata = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", int'(data), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Bad start bit: a single fall with kdata high.
        v0 = vcnt; e0 = ecnt;
        send_bit(1'b1);
        repeat (4) @(negedge clk);
        check("badstart_err", ecnt - e0, 1);
        check("badstart_valid", vcnt - v0, 0);
        check("badstart_busy", int'(busy), 0);

        // Table of back-to-back frames.
        for (int i = 0; i < 8; i++) begin
            v0 = vcnt; e0 = ecnt;
            send_frame(vecs[i].b, vecs[i].par_flip, vecs[i].stop_b, lat);
            check($sformatf("vec%0d_valid", i), vcnt - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), ecnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_data", i), int'(data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
            check($sformatf("vec%0d_latency", i), lat, 3 + EXTRA);
        end

        // Timeout: start plus 3 data bits, then silence.
        repeat (10) @(negedge clk);
        v0 = vcnt; e0 = ecnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        kdata = 1'b1;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        lat = 0;
        for (int i = 1; i <= T + 60; i++) begin
            @(posedge clk);
            #1;
            if (i == H) kclk = 1'b1;
            if (err && lat == 0) lat = i;
        end
        check("timeout_latency", lat, T + 3 + EXTRA);
        check("timeout_err", ecnt - e0, 1);
        check("timeout_valid", vcnt - v0, 0);
        check("timeout_busy", int'(busy), 0);
        v0 = vcnt; e0 = ecnt;
        send_frame(8'h1C, 1'b0, 1'b1, lat);
        check("after_to_valid", vcnt - v0, 1);
        check("after_to_err", ecnt - e0, 0);
        check("after_to_data", int'(data), 8'h1C);

        // Reset in the middle of a frame.
        repeat (10) @(negedge clk);
        v0 = vcnt; e0 = ecnt;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #1;
        check("midframe_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_data", int'(data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_err", int'(err), 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_pulse", (vcnt - v0) + (ecnt - e0), 0);
        send_frame(8'h5A, 1'b0, 1'b1, lat);
        check("after_rst_valid", vcnt - v0, 1);
        check("after_rst_err", ecnt - e0, 0);
        check("after_rst_data", int'(data), 8'h5A);

        // Short low glitches on kclk inside every high phase of a 0x1C frame.
        repeat (10) @(negedge clk);
        v0 = vcnt; e0 = ecnt;
        d = 8'h1C;
        glitch_bit(1'b0);
        for (int i = 0; i < 8; i++) glitch_bit(d[i]);
        glitch_bit(~^d);
        glitch_bit(1'b1);
        repeat (10) @(negedge clk);
`ifdef PS2_FILTER_EN
        check("glitch_valid", vcnt - v0, 1);
        check("glitch_err", ecnt - e0, 0);
        check("glitch_data", int'(data), 8'h1C);
`else
        check("glitch_unfiltered_corrupt",
              int'(!((vcnt - v0) == 1 && (ecnt - e0) == 0 && data == 8'h1C)), 1);
`endif
        repeat (T + 50) @(negedge clk);
        check("valid_err_exclusive", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
